// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: multi-field pipeline register with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 4,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*NUM_FIELDS-1:0] out_data,
  output logic [CNT_W-1:0]             stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [DATA_W*NUM_FIELDS-1:0] m_q, s_q, m_nx, s_nx;
  logic push, pop;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data  = m_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    m_nx     = m_q;
    s_nx     = s_q;
    if (flush) begin
      state_nx = EMPTY;
      if (FLUSH_ZERO != 0) begin
        m_nx = '0;
        s_nx = '0;
      end
    end else begin
      case (state)
        EMPTY: if (push) begin
          m_nx     = in_data;
          state_nx = ONE;
        end
        ONE: if (push && pop) m_nx = in_data;
          else if (push) begin
            s_nx     = in_data;
            state_nx = TWO;
          end else if (pop) state_nx = EMPTY;
        TWO: if (pop) begin
          m_nx     = s_q;
          state_nx = ONE;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      state <= state_nx;
      m_q   <= m_nx;
      s_q   <= s_nx;
    end
  end
  // saturating count of cycles the consumer holds us off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized + directed scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  logic clk = 0, reset = 1;
  logic flush = 0, in_valid = 0, out_ready = 0;
  logic [127:0] in_data = '0;
  logic in_ready, out_valid;
  logic [127:0] out_data;
  logic [15:0] stall_cnt;
  logic v2 = 0, r2 = 0, f2 = 0;
  logic [15:0] dat2 = '0;
  logic rdy2, val2;
  logic [15:0] out2;
  logic [3:0] st2;
  int total = 0, bad = 0;
  int model_stall = 0;
  logic [127:0] exp_q[$];
  bit hold_next = 0;
  logic [127:0] last_d = '0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(8), .NUM_FIELDS(2), .FLUSH_ZERO(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .flush(f2), .in_valid(v2), .in_ready(rdy2),
    .in_data(dat2), .out_valid(val2), .out_ready(r2), .out_data(out2),
    .stall_cnt(st2)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit v, input logic [127:0] d, input bit r, input bit f);
    @(negedge clk);
    if (hold_next) assert (v && d == last_d) else $error("upstream changed a stalled bundle");
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #4;
    if (v && in_ready && !f && !reset) exp_q.push_back(d);
    hold_next = v && !in_ready && !f;
    last_d = d;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // occupancy of the expected queue is the reference for valid/ready/data
  always @(negedge clk) begin
    int occ;
    occ = exp_q.size();
    if (!reset) begin
      chk("out_valid", out_valid, occ != 0);
      chk("in_ready", in_ready, occ < 2);
      chk("stall_cnt", stall_cnt, model_stall);
      if (occ != 0) chk("out_data", out_data, exp_q[0]);
    end
    #4;
    if (reset) begin
      exp_q.delete();
      model_stall = 0;
    end else if (flush) exp_q.delete();
    else if (occ != 0) begin
      if (!out_ready && model_stall < 65535) model_stall++;
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 128'h11 + 128'(i), 1, 0);
      chk("stream_ready", in_ready, 1);
    end
    cycle(0, 0, 1, 0);
    @(posedge clk) #1 chk("stream_drain", out_valid, 0);
    cycle(1, 128'hA, 0, 0);
    cycle(1, 128'hB, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(posedge clk) #1;
    chk("skid_ready", in_ready, 0);
    chk("skid_stall", stall_cnt, 3);
    chk("skid_head", out_data, 128'hA);
    cycle(0, 0, 1, 0);
    @(posedge clk) #1 chk("skid_second", out_data, 128'hB);
    cycle(0, 0, 1, 0);
    @(posedge clk) #1 chk("skid_empty", out_valid, 0);
    cycle(1, 128'hC0DE, 0, 0);
    cycle(1, 128'hD00D, 0, 0);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_stall", stall_cnt, 0);
    @(negedge clk) reset = 0;
    hold_next = 0;
    cycle(1, 128'hC, 0, 0);
    cycle(1, 128'hD, 0, 0);
    cycle(1, 128'hE, 1, 1);
    @(posedge clk) #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_data", out_data, 0);
    chk("flush_ready", in_ready, 1);
    cycle(1, 128'hF, 1, 0);
    cycle(0, 0, 1, 0);
    @(negedge clk);
    v2 = 1; dat2 = 16'hBEEF; r2 = 0;
    @(negedge clk);
    v2 = 0; dat2 = '0;
    #1;
    chk("field0", out2[7:0], 8'hEF);
    chk("field1", out2[15:8], 8'hBE);
    chk("fields_valid", val2, 1);
    repeat (20) @(negedge clk);
    chk("sat_stall", st2, 15);
    chk("sat_valid", val2, 1);
    r2 = 1;
    @(negedge clk);
    chk("sat_drain", val2, 0);
    chk("sat_hold", st2, 15);
    r2 = 0;
    for (int i = 0; i < 2000; i++) begin
      bit v;
      logic [127:0] d;
      v = hold_next ? 1'b1 : 1'($urandom_range(0, 1));
      d = hold_next ? last_d : rnd128();
      cycle(v, d, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    repeat (3) cycle(0, 0, 1, 0);
    @(posedge clk) #1;
    chk("soak_queue_empty", exp_q.size(), 0);
    chk("soak_valid", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
